// File: rtl/text_console_writer.sv
// Text console writer: turns a byte stream into writes to a row-major character memory.
// Printable bytes are stored at the cursor. A small set of control codes moves the cursor,
// clears the screen or scrolls it. The memory is an external synchronous-read RAM.
module text_console_writer #(
  parameter int unsigned COLS = 64,
  parameter int unsigned ROWS = 24
) (
  input  logic                            CLOCK_50,
  input  logic                            RESET_N,
  input  logic                            in_valid,
  input  logic [7:0]                      in_data,
  output logic                            in_ready,
  output logic [$clog2(COLS*ROWS)-1:0]    mem_addr,
  output logic [7:0]                      mem_wdata,
  output logic                            mem_we,
  input  logic [7:0]                      mem_rdata,
  output logic [$clog2(COLS)-1:0]         cursor_col,
  output logic [$clog2(ROWS)-1:0]         cursor_row,
  output logic                            busy
);

  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned AW = $clog2(COLS * ROWS);

  localparam logic [CW-1:0] LastCol      = CW'(COLS - 1);
  localparam logic [RW-1:0] LastRow      = RW'(ROWS - 1);
  localparam logic [AW-1:0] ColsA        = AW'(COLS);
  localparam logic [AW-1:0] ClearEnd     = AW'(COLS * ROWS);
  localparam logic [AW-1:0] CopyLast     = AW'((ROWS - 1) * COLS - 1);
  localparam logic [AW-1:0] LastLineBase = AW'((ROWS - 1) * COLS);
  localparam logic [AW-1:0] LineLast     = AW'(COLS - 1);

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StPut       = 3'd1;
  localparam logic [2:0] StClear     = 3'd2;
  localparam logic [2:0] StScrollRd  = 3'd3;
  localparam logic [2:0] StScrollWr  = 3'd4;
  localparam logic [2:0] StClearLine = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  // In a scroll write the data is the RAM's registered read output, which only moves on edges.
  logic          fwd_q, fwd_d;
  // PUT advances the cursor for printable bytes; backspace has already moved it.
  logic          adv_q, adv_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;

  logic [AW-1:0] cur_addr, bs_addr;
  logic [CW-1:0] bs_col;
  logic [RW-1:0] bs_row;

  // Cursor address and the position one step back from the cursor.
  always_comb begin
    bs_col   = (col_q == '0) ? LastCol : col_q - 1'b1;
    bs_row   = (col_q == '0) ? row_q - 1'b1 : row_q;
    cur_addr = AW'(col_q) + AW'(row_q) * ColsA;
    bs_addr  = AW'(bs_col) + AW'(bs_row) * ColsA;
  end

  // Next-state, cursor and memory-port decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    fwd_d   = 1'b0;
    adv_d   = adv_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready_q) begin
          if (in_data >= 8'h20) begin
            state_d = StPut;
            we_d    = 1'b1;
            addr_d  = cur_addr;
            wdata_d = in_data;
            adv_d   = 1'b1;
          end else begin
            case (in_data)
              8'h0A: begin
                col_d = '0;
                if (row_q == LastRow) begin
                  state_d = StScrollRd;
                  cnt_d   = '0;
                  addr_d  = ColsA;
                end else begin
                  row_d = row_q + 1'b1;
                end
              end
              8'h0D: col_d = '0;
              8'h08: begin
                if (!(col_q == '0 && row_q == '0)) begin
                  col_d   = bs_col;
                  row_d   = bs_row;
                  state_d = StPut;
                  we_d    = 1'b1;
                  addr_d  = bs_addr;
                  wdata_d = 8'h00;
                  adv_d   = 1'b0;
                end
              end
              8'h0C: begin
                state_d = StClear;
                cnt_d   = '0;
              end
              default: ;
            endcase
          end
        end
      end
      StPut: begin
        state_d = StIdle;
        if (adv_q) begin
          if (col_q == LastCol) begin
            col_d = '0;
            if (row_q == LastRow) begin
              state_d = StScrollRd;
              cnt_d   = '0;
              addr_d  = ColsA;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StClear: begin
        if (cnt_q == ClearEnd) begin
          state_d = StIdle;
          col_d   = '0;
          row_d   = '0;
        end else begin
          we_d    = 1'b1;
          addr_d  = cnt_q;
          wdata_d = 8'h00;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      StScrollRd: begin
        state_d = StScrollWr;
        we_d    = 1'b1;
        addr_d  = cnt_q;
        fwd_d   = 1'b1;
      end
      StScrollWr: begin
        if (cnt_q == CopyLast) begin
          state_d = StClearLine;
          cnt_d   = '0;
          we_d    = 1'b1;
          addr_d  = LastLineBase;
          wdata_d = 8'h00;
        end else begin
          state_d = StScrollRd;
          cnt_d   = cnt_q + 1'b1;
          addr_d  = cnt_q + ColsA + AW'(1);
        end
      end
      StClearLine: begin
        if (cnt_q == LineLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          we_d    = 1'b1;
          addr_d  = addr_q + 1'b1;
          wdata_d = 8'h00;
        end
      end
      default: state_d = StIdle;
    endcase
    in_ready_d = (state_d == StIdle);
    busy_d     = (state_d != StIdle);
  end

  // State and registered outputs; reset lands in CLEAR so the screen is wiped afterwards.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= StClear;
      cnt_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 8'h00;
      fwd_q      <= 1'b0;
      adv_q      <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      fwd_q      <= fwd_d;
      adv_q      <= adv_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = fwd_q ? mem_rdata : wdata_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: RAM model, write scoreboard and directed byte sequences.
module tb_text_console_writer;

  logic        CLOCK_50;
  logic        RESET_N;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [10:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  text_console_writer dut (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Synchronous-read character RAM.
  logic [7:0] ram [0:1535];
  always @(posedge CLOCK_50) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic [10:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] shadow [0:1535];
  int         checks = 0;
  int         errors = 0;
  int         wr_seen = 0;

  task automatic push_write(input int a, input logic [7:0] d);
    wr_t w;
    w.a = 11'(a);
    w.d = d;
    exp_q.push_back(w);
    shadow[a] = d;
  endtask

  task automatic push_clear();
    for (int i = 0; i < 1536; i++) push_write(i, 8'h00);
  endtask

  task automatic push_scroll();
    for (int k = 0; k < 1472; k++) push_write(k, shadow[k + 64]);
    for (int j = 0; j < 64; j++) push_write(1472 + j, 8'h00);
  endtask

  // Monitor: every write the DUT makes must match the head of the scoreboard.
  always @(negedge CLOCK_50) begin
    wr_t e;
    if (RESET_N === 1'b1 && mem_we === 1'b1) begin
      wr_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0h, no write required", mem_addr,
                 mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.a || mem_wdata !== e.d) begin
          errors++;
          $display("FAIL write: addr %0d data %0h, required addr %0d data %0h", mem_addr,
                   mem_wdata, e.a, e.d);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_cursor(input string name, input int col, input int row);
    check({name, "_col"}, 32'(cursor_col), col);
    check({name, "_row"}, 32'(cursor_row), row);
  endtask

  // Offers one byte and returns #1 after the edge that accepted it.
  task automatic send(input logic [7:0] b, input bit hold, output int waited);
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 5000) begin
      @(posedge CLOCK_50);
      #1;
      waited++;
    end
    if (waited >= 5000) begin
      check("send_timeout", 32'(waited), 0);
    end else begin
      @(posedge CLOCK_50);
      #1;
    end
    if (!hold) in_valid = 1'b0;
  endtask

  // Counts busy cycles and write cycles until busy drops, with a cycle budget.
  task automatic wait_idle(input int budget, output int busy_cyc, output int we_cyc,
                           output int first_we, output int last_we);
    bit done;
    busy_cyc = 0;
    we_cyc   = 0;
    first_we = -1;
    last_we  = -1;
    done     = 1'b0;
    while (!done) begin
      @(negedge CLOCK_50);
      if (busy !== 1'b1) begin
        done = 1'b1;
      end else begin
        if (mem_we === 1'b1) begin
          if (first_we < 0) first_we = busy_cyc;
          last_we = busy_cyc;
          we_cyc++;
        end
        busy_cyc++;
        if (busy_cyc > budget) begin
          check("idle_timeout", 32'(busy_cyc), 32'(budget));
          done = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int w, bc, wc, fw, lw, base, n;
    for (int i = 0; i < 1536; i++) shadow[i] = 8'h00;
    in_valid = 1'b0;
    in_data  = 8'h00;
    RESET_N  = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_busy", 32'(busy), 1);
    check_cursor("rst_cursor", 0, 0);

    // Power-up clear.
    push_clear();
    RESET_N = 1'b1;
    wait_idle(3000, bc, wc, fw, lw);
    check("clear_we_cycles", 32'(wc), 1536);
    check("clear_we_contiguous", 32'(lw - fw + 1), 1536);
    check("clear_in_ready", 32'(in_ready), 1);
    check("clear_busy", 32'(busy), 0);
    check_cursor("clear_cursor", 0, 0);
    check("clear_sb_empty", 32'(exp_q.size()), 0);

    // CR, BEL and BS at home: nothing written, nothing moves.
    send(8'h0D, 1'b0, w);
    check("cr_ready_next", 32'(in_ready), 1);
    send(8'h07, 1'b0, w);
    check("bel_wait", 32'(w), 0);
    check("bel_ready_next", 32'(in_ready), 1);
    send(8'h08, 1'b0, w);
    check("bs00_wait", 32'(w), 0);
    check("bs00_ready_next", 32'(in_ready), 1);
    check_cursor("ctrl_home", 0, 0);

    // Two printable bytes back to back with in_valid held.
    push_write(0, 8'h41);
    push_write(1, 8'h42);
    send(8'h41, 1'b1, w);
    check("put_a_ready_low", 32'(in_ready), 0);
    check("put_a_we", 32'(mem_we), 1);
    send(8'h42, 1'b0, w);
    check("put_b_wait", 32'(w), 1);
    check("put_b_ready_low", 32'(in_ready), 0);
    @(posedge CLOCK_50);
    #1;
    check_cursor("ab_cursor", 2, 0);

    send(8'h0D, 1'b0, w);
    check_cursor("cr_cursor", 0, 0);
    for (int i = 0; i < 5; i++) send(8'h0A, 1'b0, w);
    check_cursor("lf5_cursor", 0, 5);

    // Fill row 5 up to col 63, then wrap and back up across the row boundary.
    for (int i = 0; i < 63; i++) begin
      push_write(320 + i, 8'(8'h61 + (i % 26)));
      send(8'(8'h61 + (i % 26)), 1'b0, w);
    end
    @(posedge CLOCK_50);
    #1;
    check_cursor("row5_end", 63, 5);
    push_write(383, 8'h5A);
    send(8'h5A, 1'b0, w);
    @(posedge CLOCK_50);
    #1;
    check_cursor("wrap_cursor", 0, 6);
    push_write(383, 8'h00);
    send(8'h08, 1'b0, w);
    @(posedge CLOCK_50);
    #1;
    check_cursor("bs_wrap_cursor", 63, 5);
    @(negedge CLOCK_50);
    check("bs_sb_empty", 32'(exp_q.size()), 0);

    // Move to (10,23).
    for (int i = 0; i < 18; i++) send(8'h0A, 1'b0, w);
    check_cursor("lf_row23", 0, 23);
    for (int i = 0; i < 10; i++) begin
      push_write(1472 + i, 8'(8'h30 + i));
      send(8'(8'h30 + i), 1'b0, w);
    end
    @(posedge CLOCK_50);
    #1;
    check_cursor("row23_col10", 10, 23);

    // LF on the last row scrolls the screen up one row.
    push_scroll();
    send(8'h0A, 1'b0, w);
    check_cursor("scroll_start_cursor", 0, 23);
    wait_idle(5000, bc, wc, fw, lw);
    check("scroll_busy_cycles", 32'(bc), 3008);
    check("scroll_we_cycles", 32'(wc), 1536);
    check_cursor("scroll_end_cursor", 0, 23);
    check("scroll_sb_empty", 32'(exp_q.size()), 0);
    check("scroll_in_ready", 32'(in_ready), 1);

    // Reset in the middle of a scroll.
    push_scroll();
    base = wr_seen;
    send(8'h0A, 1'b0, w);
    n = 0;
    while (wr_seen - base < 500 && n < 3000) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("midscroll_reached", 32'(wr_seen - base), 500);
    @(posedge CLOCK_50);
    #1;
    RESET_N = 1'b0;
    exp_q.delete();
    #1;
    check("abort_mem_we", 32'(mem_we), 0);
    check("abort_busy", 32'(busy), 1);
    check("abort_in_ready", 32'(in_ready), 0);
    push_clear();
    @(posedge CLOCK_50);
    #1;
    RESET_N = 1'b1;
    wait_idle(3000, bc, wc, fw, lw);
    check("reclear_we_cycles", 32'(wc), 1536);
    check("reclear_we_contiguous", 32'(lw - fw + 1), 1536);
    check_cursor("reclear_cursor", 0, 0);
    check("reclear_sb_empty", 32'(exp_q.size()), 0);
    check("reclear_in_ready", 32'(in_ready), 1);

    repeat (2) @(posedge CLOCK_50);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_console_writer.md
TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

Interface
REQ-001 SHALL have parameter COLS, default 64, characters per text row.
REQ-002 SHALL have parameter ROWS, default 24, text rows per screen; the character memory holds COLS*ROWS = 1536 bytes, row-major, addr = col + row*COLS.
REQ-003 SHALL have port CLOCK_50  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET_N  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  character byte offered.
REQ-006 SHALL have port in_data  input  8  character byte or control code.
REQ-007 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL have port mem_addr  output  11  character memory address.
REQ-009 SHALL have port mem_wdata  output  8  character memory write data.
REQ-010 SHALL have port mem_we  output  1  character memory write strobe.
REQ-011 SHALL have port mem_rdata  input  8  memory read data, valid the cycle after mem_addr is presented.
REQ-012 SHALL have port cursor_col  output  6  current cursor column, 0..COLS-1.
REQ-013 SHALL have port cursor_row  output  5  current cursor row, 0..ROWS-1.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL drive all outputs from registers; mem_addr, mem_wdata and mem_we SHALL change only on a clock edge.
REQ-016 SHALL implement states IDLE, PUT, CLEAR, SCROLL_RD, SCROLL_WR, CLEAR_LINE.
REQ-017 SHALL assert in_ready only in IDLE; a byte is accepted when in_valid && in_ready.
REQ-018 SHALL, on accepting a byte 0x20..0xFF, enter PUT for exactly one cycle with mem_we=1, mem_addr=cursor, mem_wdata=byte, then advance the cursor; peak throughput is one byte per 2 cycles.
REQ-019 SHALL advance the cursor as col+1; at col=COLS-1 set col=0, row+1; at row=ROWS-1 set col=0, keep row=ROWS-1, and enter SCROLL_RD.
REQ-020 SHALL treat 0x0A (LF) as col=0, row+1, scrolling as in REQ-019 at the last row, with no character write.
REQ-021 SHALL treat 0x0D (CR) as col=0 with no write and no state change.
REQ-022 SHALL treat 0x08 (BS) as follows: move the cursor back one position, crossing to col COLS-1 of row-1 at col=0; then write 0x00 at the new position via PUT. At (0,0), BS is consumed with no write.
REQ-023 SHALL treat 0x0C (FF) as a full clear: enter CLEAR, write 0x00 to addresses 0..1535 in ascending order at one write per cycle (1536 cycles), then set the cursor to (0,0) and return to IDLE.
REQ-024 SHALL consume all other codes 0x00..0x1F in one cycle with no write and no cursor change.
REQ-025 SHALL scroll by alternating SCROLL_RD and SCROLL_WR for k = 0..(ROWS-1)*COLS-1:
- SCROLL_RD: mem_addr=k+COLS, mem_we=0.
- SCROLL_WR: mem_addr=k, mem_wdata=mem_rdata, mem_we=1.
The copy totals 2944 cycles.
REQ-026 SHALL, after the scroll copy, enter CLEAR_LINE and write 0x00 to addresses 1472..1535 in 64 cycles, then return to IDLE.
REQ-027 SHALL hold mem_we=0 in IDLE and in every cycle without a write.
REQ-028 SHALL hold the cursor outputs constant during CLEAR, SCROLL_* and CLEAR_LINE, except the final cursor update in REQ-023.
REQ-029 SHALL ignore in_valid while busy; bytes are neither lost nor accepted, because in_ready=0.

Reset
REQ-030 SHALL, while RESET_N=0, force: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cursor=(0,0), busy=1, state=CLEAR, clear counter=0.
REQ-031 SHALL, after RESET_N is released, perform the full clear of REQ-023 and then enter IDLE.
REQ-032 SHALL, when reset is asserted mid-PUT, mid-scroll or mid-clear, abort immediately with no further writes; the partially updated memory is overwritten by the post-reset clear.

Verification
REQ-033 Release reset -> mem_we=1 for exactly 1536 consecutive cycles, addresses 0..1535 with data 0x00; then in_ready=1, busy=0, cursor (0,0).
REQ-034 Send 0x41, 0x42 back-to-back with in_valid held high -> write 0x41@0 and 0x42@1, in_ready low on each PUT cycle, cursor (2,0).
REQ-035 Cursor (63,5), send 0x5A -> write 0x5A@383, cursor (0,6); then send 0x08 -> write 0x00@383, cursor (63,5).
REQ-036 Cursor (10,23), send 0x0A -> 1472 reads at k+64 each followed by a write at k carrying the read data, then 0x00 written @1472..1535, cursor (0,23), 3008 busy cycles.
REQ-037 Assert RESET_N=0 for 1 cycle at k=500 of a scroll -> mem_we=0 at once; after release the full clear of REQ-033 runs and the cursor is (0,0).
REQ-038 Send 0x0D, 0x07, then 0x08 at (0,0) -> no mem_we pulses, cursor (0,0), each byte consumed within 2 cycles.
